// File: rtl/l1_cache_pkg.sv
// Shared types, widths and address helpers for the L1 data cache.
// Direct-mapped, one word per line, 16-word address space.
package l1_cache_pkg;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;
  localparam int INDEX_W = 2;
  localparam int TAG_W   = ADDR_W - INDEX_W;
  localparam int NLINES  = 1 << INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL,
    WRITE,
    RESP
  } cache_state_t;

  function automatic logic [INDEX_W-1:0] addr_index(
    input logic [ADDR_W-1:0] a
  );
    return a[INDEX_W-1:0];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(
    input logic [ADDR_W-1:0] a
  );
    return a[ADDR_W-1:INDEX_W];
  endfunction

endpackage

// File: rtl/l1_cache_array.sv
// Valid/tag/data storage: one lookup port, one install/update port,
// one snoop-invalidate port. Snoop wins over a same-edge install.
module l1_cache_array
  import l1_cache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] lk_index,
  input  logic [TAG_W-1:0]   lk_tag,
  output logic               lk_hit,
  output logic [DATA_W-1:0]  lk_data,
  input  logic               wr_en,
  input  logic               wr_install,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               snoop_valid,
  input  logic [INDEX_W-1:0] snoop_index,
  input  logic [TAG_W-1:0]   snoop_tag
);

  logic [NLINES-1:0] valid;
  logic [TAG_W-1:0]  tags [NLINES];
  logic [DATA_W-1:0] data [NLINES];
  logic              snoop_kill;

  assign lk_hit  = valid[lk_index] && (tags[lk_index] == lk_tag);
  assign lk_data = data[lk_index];

  // A line being installed this edge counts as matching the snoop too.
  assign snoop_kill = snoop_valid && (
    (valid[snoop_index] && (tags[snoop_index] == snoop_tag)) ||
    (wr_en && wr_install &&
     (wr_index == snoop_index) && (wr_tag == snoop_tag)));

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else begin
      if (wr_en && wr_install) valid[wr_index] <= 1'b1;
      if (snoop_kill) valid[snoop_index] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data[wr_index] <= wr_data;
      if (wr_install) tags[wr_index] <= wr_tag;
    end
  end

endmodule

// File: rtl/l1_cache_ctrl.sv
// Write-through, no-write-allocate L1 controller with snoop invalidate.
// One request in flight; responses are a one-cycle pulse in RESP.
module l1_cache_ctrl
  import l1_cache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic [ADDR_W-1:0] mem_address_read,
  input  logic [DATA_W-1:0] mem_readed,
  input  logic [TAG_W-1:0]  mem_tag_bit,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address_write,
  output logic [DATA_W-1:0] mem_data_write,
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr
);

  cache_state_t      state, next;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              hit;
  logic [DATA_W-1:0] line_data;
  logic              wr_en;
  logic              in_fill;
  logic              accept;

  assign req_ready  = (state == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);
  assign mem_write  = (state == WRITE) && !reset;
  assign in_fill    = (state == FILL);

  assign mem_address_read  = addr_q;
  assign mem_address_write = addr_q;
  assign mem_data_write    = wdata_q;

  // Stores only touch the array when the line is resident.
  assign wr_en = !reset && (in_fill || ((state == WRITE) && hit));

  l1_cache_array u_array (
    .clk         (clk),
    .reset       (reset),
    .lk_index    (addr_index(addr_q)),
    .lk_tag      (addr_tag(addr_q)),
    .lk_hit      (hit),
    .lk_data     (line_data),
    .wr_en       (wr_en),
    .wr_install  (in_fill),
    .wr_index    (addr_index(addr_q)),
    .wr_tag      (in_fill ? mem_tag_bit : addr_tag(addr_q)),
    .wr_data     (in_fill ? mem_readed : wdata_q),
    .snoop_valid (snoop_valid),
    .snoop_index (addr_index(snoop_addr)),
    .snoop_tag   (addr_tag(snoop_addr))
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      resp_hit   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state <= next;
      if (state == LOOKUP) begin
        if (we_q) begin
          resp_hit <= hit;
        end else if (hit) begin
          resp_hit   <= 1'b1;
          resp_rdata <= line_data;
        end
      end
      if (in_fill) begin
        resp_hit   <= 1'b0;
        resp_rdata <= mem_readed;
      end
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (req_valid) next = LOOKUP;
      LOOKUP:  next = we_q ? WRITE : (hit ? RESP : FILL);
      FILL:    next = RESP;
      WRITE:   next = RESP;
      RESP:    next = IDLE;
      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Directed bench for l1_cache_ctrl with a 16-word memory model.
// Request table plus hand-written snoop and reset sequences.
module tb_l1_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_hit;
  logic [31:0] resp_rdata;
  logic [3:0]  mem_address_read, mem_address_write;
  logic [31:0] mem_readed, mem_data_write;
  logic [1:0]  mem_tag_bit;
  logic        mem_write;
  logic        snoop_valid;
  logic [3:0]  snoop_addr;
  logic [31:0] snoop_wdata;
  logic        preload;

  logic [31:0] mem [16];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  l1_cache_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_we            (req_we),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_rdata        (resp_rdata),
    .resp_hit          (resp_hit),
    .mem_address_read  (mem_address_read),
    .mem_readed        (mem_readed),
    .mem_tag_bit       (mem_tag_bit),
    .mem_write         (mem_write),
    .mem_address_write (mem_address_write),
    .mem_data_write    (mem_data_write),
    .snoop_valid       (snoop_valid),
    .snoop_addr        (snoop_addr)
  );

  assign mem_readed  = mem[mem_address_read];
  assign mem_tag_bit = mem_address_read[3:2];

  function automatic logic [31:0] init_val(input int i);
    case (i)
      4:       return 32'd1;
      14:      return 32'd7;
      15:      return 32'd15;
      default: return 32'h100 + i;
    endcase
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else begin
      if (mem_write) mem[mem_address_write] <= mem_data_write;
      if (snoop_valid) mem[snoop_addr] <= snoop_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    bit          we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    bit          hit;
  } vec_t;

  // Issues one request; optionally pulses a snoop write on cycle snoop_at.
  task automatic do_req(
    input bit we, input logic [3:0] addr, input logic [31:0] wdata,
    input int snoop_at, input logic [3:0] s_addr, input logic [31:0] s_data,
    output int lat, output logic [31:0] rdata, output logic hit,
    output int wcnt, output logic [3:0] wa, output logic [31:0] wd);
    int n;
    bit got;
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0; got = 0; wcnt = 0; lat = -1;
    rdata = 'x; hit = 1'bx; wa = 'x; wd = 'x;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (n == snoop_at) begin
        snoop_valid = 1'b1;
        snoop_addr  = s_addr;
        snoop_wdata = s_data;
      end else begin
        snoop_valid = 1'b0;
      end
      if (mem_write) begin
        wcnt++;
        wa = mem_address_write;
        wd = mem_data_write;
      end
      if (resp_valid) begin
        got = 1; lat = n; rdata = resp_rdata; hit = resp_hit;
      end
    end
    snoop_valid = 1'b0;
    if (!got) begin
      total++;
      $display("FAIL resp_timeout: got none expected resp_valid addr %0d", addr);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v,
                         input int snoop_at, input logic [3:0] s_addr,
                         input logic [31:0] s_data);
    int lat, wcnt;
    logic [31:0] rd, wd;
    logic h;
    logic [3:0] wa;
    do_req(v.we, v.addr, v.wdata, snoop_at, s_addr, s_data,
           lat, rd, h, wcnt, wa, wd);
    chk({tag, "_lat"}, lat, v.lat);
    chk({tag, "_hit"}, {31'd0, h}, {31'd0, v.hit});
    if (v.we) begin
      chk({tag, "_wcnt"}, wcnt, 1);
      chk({tag, "_waddr"}, {28'd0, wa}, {28'd0, v.addr});
      chk({tag, "_wdata"}, wd, v.wdata);
    end else begin
      chk({tag, "_wcnt"}, wcnt, 0);
      chk({tag, "_rdata"}, rd, v.rdata);
    end
  endtask

  task automatic snoop_pulse(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    snoop_valid = 1'b1;
    snoop_addr  = a;
    snoop_wdata = d;
    @(negedge clk);
    snoop_valid = 1'b0;
  endtask

  function automatic vec_t mk(input bit we, input logic [3:0] a,
                              input logic [31:0] wd, input int lat,
                              input logic [31:0] rd, input bit hit);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = wd;
    v.lat = lat; v.rdata = rd; v.hit = hit;
    return v;
  endfunction

  vec_t vecs [10];

  initial begin
    bit rv_seen;
    reset = 1'b1; preload = 1'b1;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    snoop_valid = 0; snoop_addr = 0; snoop_wdata = 0;

    vecs[0] = mk(0, 4'd4, 0, 3, 32'd1, 0);
    vecs[1] = mk(0, 4'd4, 0, 2, 32'd1, 1);
    vecs[2] = mk(0, 4'd0, 0, 3, 32'h100, 0);
    vecs[3] = mk(0, 4'd4, 0, 3, 32'd1, 0);
    vecs[4] = mk(0, 4'd5, 0, 3, 32'h105, 0);
    vecs[5] = mk(1, 4'd5, 32'hDEADBEEF, 3, 0, 1);
    vecs[6] = mk(0, 4'd5, 0, 2, 32'hDEADBEEF, 1);
    vecs[7] = mk(1, 4'd9, 32'hCAFE0009, 3, 0, 0);
    vecs[8] = mk(0, 4'd5, 0, 2, 32'hDEADBEEF, 1);
    vecs[9] = mk(0, 4'd9, 0, 3, 32'hCAFE0009, 0);

    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_hit", {31'd0, resp_hit}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    reset = 1'b0; preload = 1'b0;
    #1 chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 10; i++)
      run_vec($sformatf("vec%0d", i), vecs[i], -1, 0, 0);
    chk("mem5_written", mem[5], 32'hDEADBEEF);

    // Snoop with same index, other tag keeps line; same tag kills it.
    run_vec("t4_fill", mk(0, 4'd14, 0, 3, 32'd7, 0), -1, 0, 0);
    snoop_pulse(4'd10, 32'hAAAA0010);
    run_vec("t4_keep", mk(0, 4'd14, 0, 2, 32'd7, 1), -1, 0, 0);
    snoop_pulse(4'd14, 32'h77);
    run_vec("t4_kill", mk(0, 4'd14, 0, 3, 32'h77, 0), -1, 0, 0);

    // Snoop lands on the FILL edge: old data returned, line left invalid.
    run_vec("t5_fill", mk(0, 4'd15, 0, 3, 32'd15, 0), 2, 4'd15, 32'h42);
    run_vec("t5_miss", mk(0, 4'd15, 0, 3, 32'h42, 0), -1, 0, 0);

    // Reset arriving during WRITE drops the store entirely.
    run_vec("t6_fill", mk(0, 4'd2, 0, 3, 32'h102, 0), -1, 0, 0);
    run_vec("t6_hit", mk(0, 4'd2, 0, 2, 32'h102, 1), -1, 0, 0);
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 4'd3; req_wdata = 32'h5555;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_write_state", {31'd0, mem_write}, 32'd1);
    reset = 1'b1;
    #1 chk("t6_rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("t6_rst_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("t6_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    reset = 1'b0;
    #1 chk("t6_ready_after", {31'd0, req_ready}, 32'd1);
    rv_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) rv_seen = 1;
    end
    chk("t6_no_resp", {31'd0, rv_seen}, 32'd0);
    chk("t6_mem3_kept", mem[3], 32'h103);
    run_vec("t6_miss", mk(0, 4'd2, 0, 3, 32'h102, 0), -1, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
